// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : demux_pkg                                                  |
// | Description : Shared types, defaults and the slot-mapping helper for     |
// |               the serial demux/deserializer.                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package demux_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int SEL_W_DEF = 3;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } dmx_state_t;

   // Maps the beat counter to the bit position of the word being assembled.
   // LSB-first streams fill data[0] first; MSB-first streams fill data[WIDTH-1] first.
   function automatic int unsigned slot_idx(input int unsigned sel,
                                            input int unsigned width,
                                            input bit          msb_first);
      return msb_first ? (width - 1 - sel) : sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bit_decoder                                                |
// | Description : SEL_W -> WIDTH one-hot decoder gated by an enable; selects |
// |               which shadow bit receives the incoming serial bit.         |
// | Ports       : en_i      - enable; all outputs 0 when low                 |
// |               sel_i     - slot index                                     |
// |               onehot_o  - one-hot write strobe, bit sel_i set            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bit_decoder #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             en_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic [WIDTH-1:0] onehot_o
);

   for (genvar k = 0; k < WIDTH; k++) begin : g_dec
      assign onehot_o[k] = en_i && (sel_i == SEL_W'(k));
   end

endmodule
`default_nettype wire

// File: rtl/serial_demux_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_demux_deserializer                                  |
// | Description : 1:WIDTH demultiplexer/deserializer. Each accepted serial   |
// |               bit is written into slot data[sel] of a shadow register;   |
// |               completed words are presented with a valid/ready handshake.|
// | Ports       : clk, rst_n       - clock, async active-low reset           |
// |               bit_in/bit_valid - serial bit and its accept strobe        |
// |               frame_start      - current beat is word slot 0 (resync)    |
// |               byte_out/byte_valid/byte_ready - parallel word handshake   |
// |               sel_out          - slot index for the next accepted bit    |
// |               overflow         - sticky: a completed word was dropped    |
// |               clear_ovf        - synchronous clear of overflow           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module serial_demux_deserializer
   import demux_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int SEL_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic [SEL_W-1:0] sel_out,
   output logic             overflow,
   input  logic             clear_ovf
);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_demux_deserializer: WIDTH must be >= 2");
   end
   if ((WIDTH & (WIDTH - 1)) != 0) begin : g_bad_pow2
      $error("serial_demux_deserializer: WIDTH must be a power of 2");
   end
   if (SEL_W != $clog2(WIDTH)) begin : g_bad_selw
      $error("serial_demux_deserializer: SEL_W must equal clog2(WIDTH)");
   end

   dmx_state_t       state_q;
   logic [SEL_W-1:0] sel_q;
   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] byte_q;
   logic             byte_valid_q;
   logic             overflow_q;

   logic [SEL_W-1:0] w_sel;
   logic [SEL_W-1:0] w_slot;
   logic [WIDTH-1:0] w_onehot;
   logic [WIDTH-1:0] w_word;
   logic             w_complete;
   logic             w_load;

   // A resync beat or an idle FSM both mean "this beat is slot 0",
   // so a stale counter can never misplace the first bit of a word.
   assign w_sel = (frame_start || (state_q == IDLE)) ? '0 : sel_q;
   assign w_slot = SEL_W'(slot_idx(32'(w_sel), WIDTH, MSB_FIRST));

   bit_decoder #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_bit_decoder (
      .en_i     (bit_valid),
      .sel_i    (w_slot),
      .onehot_o (w_onehot)
   );

   // Final bit is merged combinationally so the finished word is
   // available on the same edge that accepts the last beat.
   assign w_word     = (shadow_q & ~w_onehot) | ({WIDTH{bit_in}} & w_onehot);
   assign w_complete = bit_valid && (w_sel == SEL_W'(WIDTH - 1));
   assign w_load     = w_complete && (!byte_valid_q || byte_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         shadow_q     <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (bit_valid) begin
            shadow_q <= w_word;
            sel_q    <= w_sel + SEL_W'(1);
            state_q  <= w_complete ? IDLE : COLLECT;
         end else if (frame_start) begin
            sel_q   <= '0;
            state_q <= IDLE;
         end

         // Drain-on-completion keeps byte_valid high while swapping in the new word.
         if (w_load) begin
            byte_q       <= w_word;
            byte_valid_q <= 1'b1;
         end else if (byte_valid_q && byte_ready) begin
            byte_valid_q <= 1'b0;
         end

         // Setting wins over a simultaneous clear so a drop is never lost.
         if (w_complete && !w_load) begin
            overflow_q <= 1'b1;
         end else if (clear_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = byte_valid_q;
   assign sel_out    = sel_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_demux_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_demux_deserializer                               |
// | Description : Directed self-checking bench for serial_demux_deserializer;|
// |               an LSB-first and an MSB-first instance share one stimulus. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_serial_demux_deserializer;

   logic       clk;
   logic       rst_n;
   logic       bit_in;
   logic       bit_valid;
   logic       frame_start;
   logic       byte_ready;
   logic       clear_ovf;

   logic [7:0] byte_out0, byte_out1;
   logic       byte_valid0, byte_valid1;
   logic [2:0] sel_out0, sel_out1;
   logic       overflow0, overflow1;

   int checks = 0;
   int errors = 0;

   logic [7:0] mux_data;

   serial_demux_deserializer #(
      .WIDTH     (8),
      .SEL_W     (3),
      .MSB_FIRST (1'b0)
   ) u_dut_lsb (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .byte_out    (byte_out0),
      .byte_valid  (byte_valid0),
      .byte_ready  (byte_ready),
      .sel_out     (sel_out0),
      .overflow    (overflow0),
      .clear_ovf   (clear_ovf)
   );

   serial_demux_deserializer #(
      .WIDTH     (8),
      .SEL_W     (3),
      .MSB_FIRST (1'b1)
   ) u_dut_msb (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .byte_out    (byte_out1),
      .byte_valid  (byte_valid1),
      .byte_ready  (byte_ready),
      .sel_out     (sel_out1),
      .overflow    (overflow1),
      .clear_ovf   (clear_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; the beat is consumed on the next rising
   // edge and the task returns on the following falling edge for sampling.
   task automatic beat(input logic b, input logic v, input logic fs);
      bit_in      = b;
      bit_valid   = v;
      frame_start = fs;
      @(negedge clk);
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      bit_in      = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) beat(w[i], 1'b1, 1'b0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bit_in      = 1'b0;
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      byte_ready  = 1'b0;
      clear_ovf   = 1'b0;
      mux_data    = 8'h00;

      // Reset state
      #12;
      check("rst_byte_out",   32'(byte_out0),   32'h00);
      check("rst_byte_valid", 32'(byte_valid0), 32'h0);
      check("rst_sel_out",    32'(sel_out0),    32'h0);
      check("rst_overflow",   32'(overflow0),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LSB-first / MSB-first assembly of 1,0,1,1,0,0,1,0
      byte_ready = 1'b1;
      for (int i = 0; i < 7; i++) beat(8'b0100_1101 >> i, 1'b1, 1'b0);
      check("pre_last_sel",   32'(sel_out0),    32'h7);
      check("pre_last_valid", 32'(byte_valid0), 32'h0);
      beat(1'b0, 1'b1, 1'b0);
      check("lsb_byte_out",   32'(byte_out0),   32'h4D);
      check("lsb_valid",      32'(byte_valid0), 32'h1);
      check("msb_byte_out",   32'(byte_out1),   32'hB2);
      check("msb_valid",      32'(byte_valid1), 32'h1);
      check("lsb_sel_wrap",   32'(sel_out0),    32'h0);
      beat(1'b0, 1'b0, 1'b0);
      check("lsb_valid_drop", 32'(byte_valid0), 32'h0);
      check("lsb_byte_hold",  32'(byte_out0),   32'h4D);

      // Overflow: A5 unconsumed, 3C dropped
      byte_ready = 1'b0;
      send_word(8'hA5);
      check("ovf_a_byte",  32'(byte_out0),   32'hA5);
      check("ovf_a_valid", 32'(byte_valid0), 32'h1);
      check("ovf_a_flag",  32'(overflow0),   32'h0);
      send_word(8'h3C);
      check("ovf_b_byte",  32'(byte_out0),   32'hA5);
      check("ovf_b_flag",  32'(overflow0),   32'h1);
      clear_ovf = 1'b1;
      beat(1'b0, 1'b0, 1'b0);
      clear_ovf = 1'b0;
      check("ovf_cleared",     32'(overflow0),   32'h0);
      check("ovf_valid_kept",  32'(byte_valid0), 32'h1);

      // Drain on completion: ready only in the final-bit cycle
      mux_data = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         byte_ready = (i == 7);
         beat(mux_data[i], 1'b1, 1'b0);
      end
      byte_ready = 1'b0;
      check("drain_byte",  32'(byte_out0),   32'h5A);
      check("drain_valid", 32'(byte_valid0), 32'h1);
      check("drain_ovf",   32'(overflow0),   32'h0);
      beat(1'b0, 1'b0, 1'b0);
      check("drain_hold_valid", 32'(byte_valid0), 32'h1);
      byte_ready = 1'b1;
      beat(1'b0, 1'b0, 1'b0);
      check("drain_consumed", 32'(byte_valid0), 32'h0);

      // Resync with frame_start mid-word
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b0);
      check("fs_pre_sel", 32'(sel_out0), 32'h3);
      beat(1'b1, 1'b1, 1'b1);
      check("fs_sel_one", 32'(sel_out0), 32'h1);
      for (int i = 0; i < 7; i++) beat(1'b0, 1'b1, 1'b0);
      check("fs_byte",  32'(byte_out0),   32'h01);
      check("fs_valid", 32'(byte_valid0), 32'h1);
      check("fs_sel",   32'(sel_out0),    32'h0);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 1'b0);
      check("fs_idle_pre_sel", 32'(sel_out0), 32'h2);
      beat(1'b0, 1'b0, 1'b1);
      check("fs_idle_sel", 32'(sel_out0), 32'h0);

      // Asynchronous reset mid-word
      for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 1'b0);
      check("mid_rst_pre_sel", 32'(sel_out0), 32'h5);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_byte",  32'(byte_out0),   32'h00);
      check("mid_rst_valid", 32'(byte_valid0), 32'h0);
      check("mid_rst_sel",   32'(sel_out0),    32'h0);
      check("mid_rst_ovf",   32'(overflow1),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_word(8'hFF);
      check("post_rst_byte",  32'(byte_out0),   32'hFF);
      check("post_rst_valid", 32'(byte_valid0), 32'h1);

      // Round trip through an 8:1 bit-select mux walking sel 0..7
      mux_data = 8'h96;
      for (int s = 0; s < 8; s++) begin
         if (s == 4) check("rt_sel_mid", 32'(sel_out0), 32'h4);
         beat(mux_data[s], 1'b1, 1'b0);
      end
      check("rt_byte_96", 32'(byte_out0), 32'h96);
      mux_data = 8'h3B;
      for (int s = 0; s < 8; s++) beat(mux_data[s], 1'b1, 1'b0);
      check("rt_byte_3b", 32'(byte_out0), 32'h3B);
      check("rt_msb_3b",  32'(byte_out1), 32'hDC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
